// File: rtl/cnt_mod_n_if.sv
// cnt_mod_n_if: control, load data and count outputs of one modulo-N counter stage.
// The master drives the controls; the counter stage is the slave.
interface cnt_mod_n_if #(
   parameter int WIDTH = 16
);
   logic             en;
   logic             load;
   logic             dir;
   logic [WIDTH-1:0] data;
   logic [WIDTH-1:0] dout;
   logic             cout;
   logic             lderr;

   modport master (
      output en, load, dir, data,
      input  dout, cout, lderr
   );

   modport slave (
      input  en, load, dir, data,
      output dout, cout, lderr
   );
endinterface

// File: rtl/cnt_mod_n.sv
// cnt_mod_n: modulo-MOD loadable up/down counter with cascade carry/borrow and load range check.
// Define CNT_MOD_N_BCD_EN to count in packed BCD (WIDTH/4 decimal digits) instead of binary.
module cnt_mod_n #(
   parameter int     WIDTH = 16,
   parameter longint MOD   = 57
) (
   input logic        clk,
   input logic        rst,
   cnt_mod_n_if.slave bus
);

   logic [WIDTH-1:0] cnt;
   logic [WIDTH-1:0] inc;
   logic [WIDTH-1:0] dec;
   logic             lderr_q;
   logic             digit_err;
   logic             load_bad;
   logic             at_term;

`ifdef CNT_MOD_N_BCD_EN
   localparam int DIGITS = WIDTH / 4;

   function automatic logic [WIDTH-1:0] to_bcd(input longint v);
      logic [WIDTH-1:0] r;
      longint           rem;
      r   = '0;
      rem = v;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'(rem % 10);
         rem         = rem / 10;
      end
      return r;
   endfunction

   // Decimal ripple: a digit passes the carry/borrow on only when it wraps 9->0 or 0->9.
   function automatic logic [WIDTH-1:0] bcd_step(input logic [WIDTH-1:0] v, input logic up);
      logic [WIDTH-1:0] r;
      logic             carry;
      r     = v;
      carry = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (carry) begin
            if (up) begin
               if (r[4*i +: 4] == 4'd9) r[4*i +: 4] = 4'd0;
               else begin
                  r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                  carry       = 1'b0;
               end
            end else begin
               if (r[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'd9;
               else begin
                  r[4*i +: 4] = r[4*i +: 4] - 4'd1;
                  carry       = 1'b0;
               end
            end
         end
      end
      return r;
   endfunction

   function automatic logic bad_digit(input logic [WIDTH-1:0] v);
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (v[4*i +: 4] > 4'd9) bad = 1'b1;
      end
      return bad;
   endfunction

   localparam logic [WIDTH-1:0] MAX = to_bcd(MOD - 1);

   assign inc       = bcd_step(cnt, 1'b1);
   assign dec       = bcd_step(cnt, 1'b0);
   assign digit_err = bad_digit(bus.data);
`else
   localparam logic [WIDTH-1:0] MAX = WIDTH'(MOD - 1);

   assign inc       = cnt + WIDTH'(1);
   assign dec       = cnt - WIDTH'(1);
   assign digit_err = 1'b0;
`endif

   // With valid digits, "data >= MOD" is the same as an unsigned "data > MAX" in both encodings.
   assign load_bad = digit_err || (bus.data > MAX);
   assign at_term  = bus.dir ? (cnt == MAX) : (cnt == '0);

   assign bus.cout  = rst & bus.en & bus.load & at_term;
   assign bus.dout  = cnt;
   assign bus.lderr = lderr_q;

   // NOTE: non-blocking assignments for all state so every register samples pre-edge values;
   // the async reset sits in the sensitivity list so dout clears without waiting for clk.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt     <= '0;
         lderr_q <= 1'b0;
      end else if (!bus.load) begin
         cnt     <= load_bad ? MAX : bus.data;
         lderr_q <= load_bad;
      end else begin
         lderr_q <= 1'b0;
         if (bus.en) begin
            if (bus.dir) cnt <= at_term ? '0  : inc;
            else         cnt <= at_term ? MAX : dec;
         end
      end
   end

endmodule

// File: tb/tb_cnt_mod_n.sv
// tb_cnt_mod_n: scoreboard bench for cnt_mod_n (WIDTH=16, MOD=57) against a decimal-integer model.
// Follows the design build: define CNT_MOD_N_BCD_EN for both to exercise the BCD encoding.
module tb_cnt_mod_n;
   localparam int WIDTH = 16;
   localparam int MOD   = 57;

   typedef struct {
      logic [WIDTH-1:0] dout_now;
      logic             cout;
      logic [WIDTH-1:0] dout_next;
      logic             lderr_next;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   cnt_mod_n_if #(.WIDTH(WIDTH)) bus ();

   cnt_mod_n #(.WIDTH(WIDTH), .MOD(MOD)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   exp_t sb[$];
   int   n_vec     = 0;
   int   n_err     = 0;
   int   model_cnt = 0;

   function automatic logic [WIDTH-1:0] enc(input int v);
`ifdef CNT_MOD_N_BCD_EN
      logic [WIDTH-1:0] r;
      r = '0;
      for (int i = 0; i < WIDTH / 4; i++) begin
         r[4*i +: 4] = 4'(v % 10);
         v           = v / 10;
      end
      return r;
`else
      return WIDTH'(v);
`endif
   endfunction

   function automatic bit dec_ok(input logic [WIDTH-1:0] d, output int v);
`ifdef CNT_MOD_N_BCD_EN
      v = 0;
      for (int i = WIDTH / 4 - 1; i >= 0; i--) begin
         if (d[4*i +: 4] > 4'd9) return 1'b0;
         v = v * 10 + int'(d[4*i +: 4]);
      end
      return v < MOD;
`else
      v = int'(d);
      return v < MOD;
`endif
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drives one cycle of controls and pushes what the counter must show before and after the edge.
   task automatic drive(input bit r, input bit l, input bit e, input bit d,
                        input logic [WIDTH-1:0] dat);
      exp_t x;
      int   v;
      bit   ok;
      @(negedge clk);
      rst      = r;
      bus.load = l;
      bus.en   = e;
      bus.dir  = d;
      bus.data = dat;
      if (!r) model_cnt = 0;
      x.dout_now = enc(model_cnt);
      x.cout     = r && e && l && (d ? (model_cnt == MOD - 1) : (model_cnt == 0));
      if (!r) begin
         x.lderr_next = 1'b0;
      end else if (!l) begin
         ok           = dec_ok(dat, v);
         model_cnt    = ok ? v : MOD - 1;
         x.lderr_next = !ok;
      end else begin
         x.lderr_next = 1'b0;
         if (e) model_cnt = d ? (model_cnt + 1) % MOD : (model_cnt + MOD - 1) % MOD;
      end
      x.dout_next = enc(model_cnt);
      sb.push_back(x);
   endtask

   initial begin : monitor
      logic             c;
      logic [WIDTH-1:0] dn;
      exp_t             x;
      forever begin
         @(negedge clk);
         #1;
         c  = bus.cout;
         dn = bus.dout;
         @(posedge clk);
         #1;
         if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard_empty: no expectation queued at %0t", $time);
         end else begin
            x = sb.pop_front();
            check("cout",       32'(c),         32'(x.cout));
            check("dout_pre",   32'(dn),        32'(x.dout_now));
            check("dout",       32'(bus.dout),  32'(x.dout_next));
            check("lderr",      32'(bus.lderr), 32'(x.lderr_next));
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      bus.en   = 1'b0;
      bus.load = 1'b1;
      bus.dir  = 1'b1;
      bus.data = '0;

      // Reset, then a full up-count with wrap.
      repeat (3)  drive(1'b0, 1'b1, 1'b1, 1'b1, '0);
      repeat (60) drive(1'b1, 1'b1, 1'b1, 1'b1, '0);

      // Load 7 and count down through the 0 -> 56 wrap.
      drive(1'b1, 1'b0, 1'b1, 1'b1, enc(7));
      repeat (9) drive(1'b1, 1'b1, 1'b1, 1'b0, '0);

      // Out-of-range load, then a hold cycle clears lderr.
      drive(1'b1, 1'b0, 1'b1, 1'b1, 16'h0064);
      drive(1'b1, 1'b1, 1'b0, 1'b1, '0);

      // Load wins over enable; cout suppressed while loading at a terminal count.
      drive(1'b1, 1'b0, 1'b0, 1'b1, enc(5));
      drive(1'b1, 1'b0, 1'b1, 1'b1, enc(0));
      drive(1'b1, 1'b0, 1'b1, 1'b0, enc(9));
      drive(1'b1, 1'b0, 1'b1, 1'b1, enc(56));
      drive(1'b1, 1'b1, 1'b1, 1'b1, '0);

      // Async reset between edges at count 30, with a load pending.
      drive(1'b1, 1'b0, 1'b1, 1'b1, enc(28));
      repeat (2) drive(1'b1, 1'b1, 1'b1, 1'b1, '0);
      drive(1'b0, 1'b0, 1'b1, 1'b1, enc(12));
      repeat (3) drive(1'b1, 1'b1, 1'b1, 1'b1, '0);

`ifdef CNT_MOD_N_BCD_EN
      drive(1'b1, 1'b0, 1'b1, 1'b1, 16'h0049);
      repeat (9) drive(1'b1, 1'b1, 1'b1, 1'b1, '0);
      drive(1'b1, 1'b0, 1'b1, 1'b1, 16'h004A);
      drive(1'b1, 1'b1, 1'b0, 1'b1, '0);
`endif

      repeat (400) begin
         bit               r, l, e, d;
         logic [WIDTH-1:0] dat;
         r   = ($urandom_range(0, 49) != 0);
         l   = ($urandom_range(0, 7) != 0);
         e   = ($urandom_range(0, 3) != 0);
         d   = $urandom_range(0, 1) == 1;
         dat = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom) : enc($urandom_range(0, MOD + 5));
         drive(r, l, e, d, dat);
      end

      @(posedge clk);
      #2;
      if (sb.size() != 0) begin
         n_vec++;
         n_err++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/cnt_mod_n.md
# cnt_mod_n

Parametrised modulo-N loadable up/down counter: successor to the fixed modulo-57 counter, generalised in width and modulus, with a direction control, a load range check and a cascade carry/borrow. Sits in the timer/clock-divider datapath and cascades into further counter stages through `cout`. Optionally counts in packed BCD for direct seven-segment display drive.

## Interface
- `WIDTH`, 16, counter and data width in bits; 2..32. Must be a multiple of 4 when BCD is compiled in.
- `MOD`, 57, modulus; count range is 0..MOD-1. Must satisfy 2 <= MOD <= 2^WIDTH. In BCD builds, MOD <= 10^(WIDTH/4).
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `en`  input  1  count enable, active-high.
- `load`  input  1  synchronous parallel load, active-low.
- `dir`  input  1  direction: 1 = up, 0 = down.
- `data`  input  WIDTH  load value, in binary, or in packed BCD in BCD builds.
- `dout`  output  WIDTH  current count.
- `cout`  output  1  terminal-count carry/borrow, combinational.
- `lderr`  output  1  one-cycle flag for an out-of-range load value.

## Operation
- Edge priority: `rst` low, then `load` low, then `en` high, then hold.
- Reset:
  - `rst` low forces `dout`=0 and `lderr`=0 immediately, without waiting for a clock edge.
  - `cout`=0 while `rst` is low.
- Load (`load`=0 at the edge):
  - The count takes `data`, regardless of `en` and `dir`.
  - If `data` >= MOD, or in BCD builds any nibble > 9, the count is set to MOD-1 and `lderr`=1 for that cycle.
  - Otherwise `lderr`=0.
- Count (`load`=1, `en`=1):
  - `dir`=1: count+1; MOD-1 wraps to 0.
  - `dir`=0: count-1; 0 wraps to MOD-1.
- Hold (`load`=1, `en`=0): count unchanged.
- `lderr` is registered and is 0 on every edge that does not perform an invalid load.
- `cout` = `rst` & `en` & `load` & (`dir` ? count==MOD-1 : count==0).
  - It is high exactly in the cycle before a wrap, so it can drive the next stage's `en`.
  - It is suppressed during a load cycle.
- A `dir` change takes effect on the next edge; there is no dead cycle.
- Arithmetic: the wrap comparison uses the registered count, so no intermediate value outside 0..MOD-1 is ever visible on `dout`.

## Timing
- Single clock domain.
- Reset assertion is asynchronous. Reset release is sampled at the next rising edge; the first count or load occurs on the first edge with `rst` high.
- Latency:
  - `dout` reflects a load or count one edge after the control is sampled.
  - `lderr` is aligned with the loaded `dout`.
- `cout` is combinational from `en`, `load`, `dir`, `rst` and the count register. It must settle within the same cycle for ripple-enable cascading.
- Reset mid-count: the count returns to 0 at once. A pending load on that edge is discarded.

## Configuration
- `CNT_MOD_N_BCD_EN` defined:
  - The counter register holds packed BCD with WIDTH/4 digits, and the per-digit increment/decrement ripples decimal carries.
  - MOD is a decimal value; for example MOD=57 wraps after 16'h0056.
  - `data` is checked for nibbles > 9 as well as for the MOD range.
- Undefined: pure binary counter; `data` and `dout` are binary, and only the MOD range check applies.
- Port list and reset behaviour are identical in both builds.

## Test plan
All cases use WIDTH=16, MOD=57, binary build unless stated.
- Reset/enable: `rst`=0 for 3 cycles, then `rst`=1, `en`=1, `dir`=1 for 60 cycles -> `dout`=0 during reset; counts 0..56; `cout`=1 only while `dout`=56; wraps to 0.
- Load and down count: `load`=0 one cycle with `data`=7, then `dir`=0 for 9 cycles -> `dout`=7,6,...,0,56; `cout` high only while `dout`=0.
- Invalid load: `load`=0 with `data`=16'h0064 (100) -> `dout`=56, `lderr`=1 for one cycle, then 0.
- Load vs enable: `en`=0 and `load`=0 with `data`=5 -> `dout`=5. With `en`=1 and `load`=0, the load wins and `cout`=0.
- Async reset mid-count: drop `rst` at `dout`=30 between edges -> `dout`=0 and `cout`=0 before the next edge.
- BCD build (`CNT_MOD_N_BCD_EN`):
  - Load 16'h0049 and count up -> `dout`=16'h0050, ..., 16'h0056, then 16'h0000.
  - Load 16'h004A -> `lderr`=1 and `dout`=16'h0056.
